// File: rtl/station_pkg.sv
// -----------------------------------------------------------------------------
// station_pkg
//   Shared types and constants for the station command sequencer.
//   - station_state_t : sequencer state (IDLE / TRANSIT)
//   - CMD_STOP/CMD_GO : command opcodes carried in cmd[7:6]
//   - cmd_opcode()    : extracts the opcode field from a command byte
//   - cmd_station()   : extracts the destination station from a command byte
//   - id_station()    : extracts the comparable station field from a barcode ID
// -----------------------------------------------------------------------------
package station_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    TRANSIT = 1'b1
  } station_state_t;

  localparam logic [1:0] CMD_STOP = 2'b00;
  localparam logic [1:0] CMD_GO   = 2'b01;

  function automatic logic [1:0] cmd_opcode(input logic [7:0] cmd_byte);
    return cmd_byte[7:6];
  endfunction

  function automatic logic [5:0] cmd_station(input logic [7:0] cmd_byte);
    return cmd_byte[5:0];
  endfunction

  function automatic logic [5:0] id_station(input logic [7:0] id_byte);
    return id_byte[5:0];
  endfunction

endpackage

// File: rtl/station_cntrl_buzz_gen.sv
// -----------------------------------------------------------------------------
// buzz_gen
//   Differential square-wave driver for the piezo alarm.
//   While en is high a counter runs 0..BUZZ_HALF-1 and a toggle flop flips on
//   every wrap, so the tone period is 2*BUZZ_HALF clk cycles. While en is low
//   the counter and toggle flop are held at zero and both drive legs are low,
//   so the piezo sees no DC bias when silent.
// Ports
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   en     in   alarm enable
//   buzz   out  piezo drive, positive leg
//   buzz_n out  piezo drive, negative leg (complement of buzz while enabled)
// -----------------------------------------------------------------------------
module buzz_gen #(
  parameter int BUZZ_HALF = 6250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic buzz,
  output logic buzz_n
);

  localparam int CNT_W = $clog2(BUZZ_HALF);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUZZ_HALF - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             tog_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      tog_reg <= 1'b0;
    end else if (!en) begin
      cnt_reg <= '0;
      tog_reg <= 1'b0;
    end else if (cnt_reg == CNT_LAST) begin
      cnt_reg <= '0;
      tog_reg <= ~tog_reg;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  // Gating with en makes both legs drop together the moment the alarm is
  // disabled, and keeps them complementary from the very first enabled cycle.
  assign buzz   = en &  tog_reg;
  assign buzz_n = en & ~tog_reg;

endmodule

// File: rtl/station_cntrl.sv
// -----------------------------------------------------------------------------
// station_cntrl
//   Command sequencer between the host UART receiver, the barcode reader and
//   the motor/buzzer drivers. A GO command latches a 6-bit destination station
//   and puts the robot in transit; it stays in transit until a STOP command or
//   until the barcode reader reports the destination station. Motion is
//   enabled only while in transit and the path is clear; a blocked path while
//   in transit sounds the piezo alarm.
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   cmd_rdy      in   host command byte available (held until acknowledged)
//   cmd[7:0]     in   command byte: [7:6] opcode, [5:0] station
//   clr_cmd_rdy  out  acknowledge pulse for cmd_rdy
//   ID_vld       in   barcode ID available (held until acknowledged)
//   ID[7:0]      in   barcode ID, only [5:0] is compared
//   clr_ID_vld   out  acknowledge pulse for ID_vld
//   OK2Move      in   path is obstacle-free
//   in_transit   out  robot travelling toward the destination
//   go           out  motion enable
//   buzz/buzz_n  out  differential piezo drive
// -----------------------------------------------------------------------------
module station_cntrl
  import station_pkg::*;
#(
  parameter int BUZZ_HALF = 6250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_rdy,
  input  logic [7:0] cmd,
  output logic       clr_cmd_rdy,
  input  logic       ID_vld,
  input  logic [7:0] ID,
  output logic       clr_ID_vld,
  input  logic       OK2Move,
  output logic       in_transit,
  output logic       go,
  output logic       buzz,
  output logic       buzz_n
);

  station_state_t state_reg;
  logic [5:0]     dest_reg;
  logic           in_transit_reg;

  logic [1:0]     opcode;
  logic           is_go;
  logic           is_stop;
  logic           id_match;
  logic           buzz_en;
  logic           unused_id_hi;

  assign opcode   = cmd_opcode(cmd);
  assign is_go    = cmd_rdy && (opcode == CMD_GO);
  assign is_stop  = cmd_rdy && (opcode == CMD_STOP);
  assign id_match = ID_vld && (id_station(ID) == dest_reg);

  // Upper ID bits carry reader status that this block does not use.
  assign unused_id_hi = ^ID[7:6];

  // Every command and every ID is consumed in both states (ignored opcodes
  // and IDs seen while idle are simply dropped), so the acknowledges follow
  // the request flags directly. Upstream drops the flag on the next edge,
  // which bounds each pulse to one cycle.
  always_comb begin
    clr_cmd_rdy = 1'b0;
    clr_ID_vld  = 1'b0;
    case (state_reg)
      IDLE: begin
        clr_cmd_rdy = cmd_rdy;
        clr_ID_vld  = ID_vld;
      end
      TRANSIT: begin
        clr_cmd_rdy = cmd_rdy;
        clr_ID_vld  = ID_vld;
      end
      default: begin
        clr_cmd_rdy = cmd_rdy;
        clr_ID_vld  = ID_vld;
      end
    endcase
  end

  // Command outranks the barcode ID when both arrive together: a GO retargets
  // the robot even if the ID matched the old destination, a STOP ends the
  // trip, and only an ignored opcode leaves the decision to the ID compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      dest_reg       <= 6'h00;
      in_transit_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (is_go) begin
            dest_reg       <= cmd_station(cmd);
            in_transit_reg <= 1'b1;
            state_reg      <= TRANSIT;
          end
        end
        TRANSIT: begin
          if (is_go) begin
            dest_reg <= cmd_station(cmd);
          end else if (is_stop || id_match) begin
            in_transit_reg <= 1'b0;
            state_reg      <= IDLE;
          end
        end
        default: begin
          state_reg      <= IDLE;
          in_transit_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_transit = in_transit_reg;
  assign go         = in_transit_reg & OK2Move;
  assign buzz_en    = in_transit_reg & ~OK2Move;

  buzz_gen #(
    .BUZZ_HALF(BUZZ_HALF)
  ) u_buzz_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (buzz_en),
    .buzz   (buzz),
    .buzz_n (buzz_n)
  );

endmodule

// File: doc/station_cntrl.md
# station_cntrl

Command sequencer that owns the barcode reader's ID handshake and gates robot motion. It accepts byte commands from the host UART receiver, latches a 6-bit destination station, and keeps the robot in transit until the barcode reader reports a matching station ID. While the robot is in transit it drives the motion-enable output and a piezo buzzer alarm when motion is blocked. It sits between the UART command receiver, the barcode reader and the motor/buzzer drivers.

## Interface
- BUZZ_HALF, default 6250: clk cycles per buzzer half-period (4 kHz at 50 MHz); ≥2.
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_rdy  in  1  host command byte available; held until cleared
- cmd  in  8  command byte; [7:6] opcode, [5:0] station
- clr_cmd_rdy  out  1  one-cycle pulse acknowledging cmd_rdy
- ID_vld  in  1  barcode ID available; held until cleared
- ID  in  8  barcode ID; only [5:0] compared
- clr_ID_vld  out  1  one-cycle pulse acknowledging ID_vld
- OK2Move  in  1  obstacle-free indication
- in_transit  out  1  robot is travelling toward the destination
- go  out  1  motion enable = in_transit & OK2Move
- buzz, buzz_n  out  1 each  differential piezo drive

## Operation
- Opcodes: 2'b00 STOP, 2'b01 GO (dest = cmd[5:0]); 2'b10/2'b11 are ignored but still acknowledged.
- The FSM has two states, IDLE and TRANSIT. All registers reset to 0: state = IDLE, dest = 6'h00, in_transit = 0, buzzer counter and outputs = 0.
- IDLE:
  - cmd_rdy → assert clr_cmd_rdy.
  - If the opcode is GO: load dest, set in_transit, go to TRANSIT.
  - ID_vld → assert clr_ID_vld; the ID is discarded.
- TRANSIT:
  - cmd_rdy → assert clr_cmd_rdy.
  - STOP: clear in_transit, go to IDLE.
  - GO: reload dest, stay in TRANSIT.
  - ID_vld → assert clr_ID_vld.
  - If ID[5:0] == dest (the registered value): clear in_transit, go to IDLE. Otherwise stay.
- Simultaneous cmd_rdy and ID_vld: both clears pulse in the same cycle. The command has priority:
  - A GO reloads dest and remains in TRANSIT even if the ID matched the old dest.
  - A STOP goes to IDLE.
  - An ignored opcode lets the ID comparison decide.
- Buzzer: enabled when in_transit & ~OK2Move.
  - While enabled, the counter runs 0..BUZZ_HALF-1. buzz toggles on wrap, and buzz_n = ~buzz.
  - When disabled, the counter is cleared and buzz = buzz_n = 0.
  - The counter width is $clog2(BUZZ_HALF).

## Timing
- clr_cmd_rdy and clr_ID_vld are combinational (Mealy) from state and the inputs. They last exactly one cycle because upstream drops cmd_rdy/ID_vld on the next edge.
- The state, dest and in_transit update on the edge where the clear pulse is high. in_transit is visible the cycle after cmd_rdy is sampled.
- go is combinational from in_transit and OK2Move, with zero added latency.
- First buzz rising edge: BUZZ_HALF cycles after the enable is asserted.
- Reset mid-transit: all outputs are 0 immediately (asynchronous), and pending cmd_rdy/ID_vld are handled fresh in IDLE.

## Structure
- Package station_pkg holds:
  - typedef enum logic {IDLE, TRANSIT} station_state_t
  - localparams CMD_STOP = 2'b00, CMD_GO = 2'b01
- Sub-module buzz_gen (parameter BUZZ_HALF; ports clk, rst_n, en, buzz, buzz_n) holds the counter and toggle flop.
- station_cntrl contains the FSM, the dest register and the in_transit flop.

## Test plan
- Reset, then cmd = 8'h45 with cmd_rdy → one-cycle clr_cmd_rdy; in_transit = 1 next cycle; go = 1 with OK2Move = 1.
- In TRANSIT with dest = 5, ID = 8'h03 then 8'h05 → clr_ID_vld pulses on both; in_transit stays 1 after 0x03 and drops to 0 after 0x05.
- In TRANSIT, cmd = 8'h00 → IDLE and in_transit = 0. In IDLE, ID_vld with ID = 8'h00 → clr_ID_vld pulses and there is no state change.
- In TRANSIT with dest = 5: cmd = 8'h47 and ID = 8'h05 in the same cycle → both clears pulse; the robot stays in transit with dest = 7.
- In transit with OK2Move = 0 and BUZZ_HALF = 4 → buzz period 8 cycles, buzz_n always complementary. With OK2Move = 1, buzz = buzz_n = 0 and the counter is cleared.
- Assert rst_n low mid-transit while the buzzer is active → every output is 0 asynchronously; after release, an 8'h81 command is acknowledged and leaves the block in IDLE.
